// File: rtl/seg7_pkg.sv
// Shared constants for the 7-segment scan driver: segment bit positions,
// active-high glyph table for hex values 0..F and the active-high "all off" code.
package seg7_pkg;

   // Bit positions inside the 8-bit segment word {dp,g,f,e,d,c,b,a}
   localparam int unsigned SEG_A  = 0;
   localparam int unsigned SEG_B  = 1;
   localparam int unsigned SEG_C  = 2;
   localparam int unsigned SEG_D  = 3;
   localparam int unsigned SEG_E  = 4;
   localparam int unsigned SEG_F  = 5;
   localparam int unsigned SEG_G  = 6;
   localparam int unsigned SEG_DP = 7;

   // Active-high code with every segment and the dp dark
   localparam logic [7:0] SEG_OFF = 8'h00;

   // Active-high {g,f,e,d,c,b,a} glyphs: 0-9 then A,b,C,d,E,F
   localparam logic [6:0] SEG_CODE [0:15] = '{
      7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
   };

endpackage

// File: rtl/seg7_scan_driver_if.sv
// Bus bundle between the digit source and the scan driver.
//   BCD_IN   : NUM_DIG packed 4-bit digits, [3:0] = digit0 (rightmost)
//   DP_IN    : decimal point per digit, 1 = lit
//   LZ_BLANK : 1 = blank leading zeros
//   SEG      : {dp,g,f,e,d,c,b,a} towards the display (registered in the driver)
//   SEL      : one-hot digit enable towards the display (registered in the driver)
interface seg7_scan_driver_if #(
   parameter int unsigned NUM_DIG = 4
);
   logic [4*NUM_DIG-1:0] BCD_IN;
   logic [NUM_DIG-1:0]   DP_IN;
   logic                 LZ_BLANK;
   logic [7:0]           SEG;
   logic [NUM_DIG-1:0]   SEL;

   // Source side: supplies digits, observes the display lines
   modport master (
      output BCD_IN, DP_IN, LZ_BLANK,
      input  SEG, SEL
   );

   // Driver side
   modport slave (
      input  BCD_IN, DP_IN, LZ_BLANK,
      output SEG, SEL
   );
endinterface

// File: rtl/seg7_decode.sv
// Combinational hex-to-7-segment decoder producing an active-high code.
//   value : 4-bit digit value 0..15
//   dp    : decimal point request, 1 = lit
//   blank : 1 forces every segment and the dp dark
//   seg_c : {dp,g,f,e,d,c,b,a}, active-high; polarity is applied by the caller
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] value,
   input  logic       dp,
   input  logic       blank,
   output logic [7:0] seg_c
);

   logic [6:0] code;

   // Table lookup, then map each glyph bit to its segment position
   always_comb begin
      seg_c = SEG_OFF;
      code  = SEG_CODE[value];
      if (!blank) begin
         seg_c[SEG_A]  = code[0];
         seg_c[SEG_B]  = code[1];
         seg_c[SEG_C]  = code[2];
         seg_c[SEG_D]  = code[3];
         seg_c[SEG_E]  = code[4];
         seg_c[SEG_F]  = code[5];
         seg_c[SEG_G]  = code[6];
         seg_c[SEG_DP] = dp;
      end
   end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed 7-segment display driver.
// Scans NUM_DIG digits at SCAN_HZ per digit, holding a per-frame snapshot of
// the digit inputs so a frame never mixes two source values, and blanking the
// display for GHOST_CYC cycles after each digit switch to suppress ghosting.
//   CLK_50M : system clock
//   RST     : synchronous reset, active-high
//   bus     : slave side of seg7_scan_driver_if (BCD_IN, DP_IN, LZ_BLANK in; SEG, SEL out)
module seg7_scan_driver
   import seg7_pkg::*;
#(
   parameter int unsigned CLK_FREQ    = 50_000_000,
   parameter int unsigned SCAN_HZ     = 1000,
   parameter int unsigned NUM_DIG     = 4,
   parameter int unsigned GHOST_CYC   = 8,
   parameter int unsigned SEG_ACT_LOW = 1,
   parameter int unsigned SEL_ACT_LOW = 1
) (
   input  logic             CLK_50M,
   input  logic             RST,
   seg7_scan_driver_if.slave bus
);

   localparam int unsigned DIV   = CLK_FREQ / SCAN_HZ;
   localparam int unsigned DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int unsigned IDX_W = $clog2(NUM_DIG);
   localparam int unsigned GAP_W = (GHOST_CYC > 0) ? $clog2(GHOST_CYC + 1) : 1;
   localparam int unsigned BCD_W = 4 * NUM_DIG;

   // Physical "dark" levels for the selected polarities
   localparam logic [7:0]         SEG_DARK = (SEG_ACT_LOW != 0) ? ~SEG_OFF : SEG_OFF;
   localparam logic [NUM_DIG-1:0] SEL_DARK = (SEL_ACT_LOW != 0) ? {NUM_DIG{1'b1}} : '0;

   logic [DIV_W-1:0]   div_cnt, div_nxt;
   logic [IDX_W-1:0]   idx, idx_nxt;
   logic [GAP_W-1:0]   gap, gap_nxt;
   logic [BCD_W-1:0]   snap_bcd, snap_bcd_nxt;
   logic [NUM_DIG-1:0] snap_dp, snap_dp_nxt;
   logic [7:0]         seg_q, seg_nxt;
   logic [NUM_DIG-1:0] sel_q, sel_nxt;

   logic               tick_c;
   logic [NUM_DIG-1:0] lz_c;
   logic [3:0]         cur_val_c;
   logic               cur_dp_c;
   logic               cur_blank_c;
   logic [7:0]         dec_seg_c;
   logic [NUM_DIG-1:0] sel_hot_c;

   // Leading-zero run: digit k is a candidate when it and every digit above it
   // are zero with dp dark; digit0 is never a candidate
   always_comb begin
      logic run;
      lz_c = '0;
      run  = 1'b1;
      for (int k = NUM_DIG - 1; k >= 0; k--) begin
         run     = run & (snap_bcd[4*k +: 4] == 4'd0) & ~snap_dp[k];
         lz_c[k] = run;
      end
      lz_c[0] = 1'b0;
   end

   // Current digit selection; LZ_BLANK acts live on the held snapshot
   always_comb begin
      cur_val_c   = snap_bcd[{idx, 2'b00} +: 4];
      cur_dp_c    = snap_dp[idx];
      cur_blank_c = bus.LZ_BLANK & lz_c[idx];
      sel_hot_c   = NUM_DIG'(1) << idx;
   end

   seg7_decode u_decode (
      .value (cur_val_c),
      .dp    (cur_dp_c),
      .blank (cur_blank_c),
      .seg_c (dec_seg_c)
   );

   // Next-state: divider, digit index, dead-time counter, snapshot, outputs
   always_comb begin
      div_nxt      = div_cnt;
      idx_nxt      = idx;
      gap_nxt      = gap;
      snap_bcd_nxt = snap_bcd;
      snap_dp_nxt  = snap_dp;
      seg_nxt      = SEG_DARK;
      sel_nxt      = SEL_DARK;

      tick_c = (div_cnt == DIV_W'(DIV - 1));

      if (tick_c) begin
         div_nxt = '0;
         gap_nxt = GAP_W'(GHOST_CYC);
         if (idx == IDX_W'(NUM_DIG - 1)) begin
            // Frame wrap: the only point where the inputs are sampled
            idx_nxt      = '0;
            snap_bcd_nxt = bus.BCD_IN;
            snap_dp_nxt  = bus.DP_IN;
         end else begin
            idx_nxt = idx + IDX_W'(1);
         end
      end else begin
         div_nxt = div_cnt + DIV_W'(1);
         if (gap != '0) begin
            gap_nxt = gap - GAP_W'(1);
         end
      end

      // Outputs follow the pre-edge index and gap, so the old digit holds on
      // the tick edge and the new one appears GHOST_CYC+1 edges later
      if (gap == '0) begin
         seg_nxt = (SEG_ACT_LOW != 0) ? ~dec_seg_c : dec_seg_c;
         sel_nxt = (SEL_ACT_LOW != 0) ? ~sel_hot_c : sel_hot_c;
      end
   end

   // State and output registers
   always_ff @(posedge CLK_50M) begin
      if (RST) begin
         div_cnt  <= '0;
         idx      <= '0;
         gap      <= '0;
         snap_bcd <= '0;
         snap_dp  <= '0;
         seg_q    <= SEG_DARK;
         sel_q    <= SEL_DARK;
      end else begin
         div_cnt  <= div_nxt;
         idx      <= idx_nxt;
         gap      <= gap_nxt;
         snap_bcd <= snap_bcd_nxt;
         snap_dp  <= snap_dp_nxt;
         seg_q    <= seg_nxt;
         sel_q    <= sel_nxt;
      end
   end

   assign bus.SEG = seg_q;
   assign bus.SEL = sel_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Directed bench for seg7_scan_driver: DIV=10, NUM_DIG=4, GHOST_CYC=2,
// active-low segments and selects. Edge n counts rising edges after reset release.
module tb_seg7_scan_driver;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   errors = 0;
   int   checks = 0;
   int   cyc = 0;
   logic mon_en = 1'b0;

   always #5 clk = ~clk;

   seg7_scan_driver_if #(.NUM_DIG(4)) bus ();

   seg7_scan_driver #(
      .CLK_FREQ    (1000),
      .SCAN_HZ     (100),
      .NUM_DIG     (4),
      .GHOST_CYC   (2),
      .SEG_ACT_LOW (1),
      .SEL_ACT_LOW (1)
   ) u_dut (
      .CLK_50M (clk),
      .RST     (rst),
      .bus     (bus)
   );

   typedef struct {
      int         n;
      logic [7:0] seg;
      logic [3:0] sel;
   } vec_t;

   vec_t vecs [16];

   // At most one active (low) select in every sampled cycle
   always @(negedge clk) begin
      if (mon_en) begin
         checks++;
         if (!$onehot0(~bus.SEL)) begin
            errors++;
            $display("FAIL onehot: got sel=%h, want at most one low bit (t=%0t)", bus.SEL, $time);
         end
      end
   end

   task automatic check(input string name, input logic [7:0] seg, input logic [3:0] sel);
      checks++;
      if (bus.SEG !== seg || bus.SEL !== sel) begin
         errors++;
         $display("FAIL %s: got seg=%h sel=%h, want seg=%h sel=%h (edge %0d)",
                  name, bus.SEG, bus.SEL, seg, sel, cyc);
      end
   endtask

   // One rising edge, sampled on the following falling edge
   task automatic tick_one();
      @(posedge clk);
      @(negedge clk);
      cyc++;
   endtask

   task automatic run_to(input int n);
      while (cyc < n) tick_one();
   endtask

   task automatic do_reset(input int ncyc);
      rst = 1'b1;
      repeat (ncyc) begin
         tick_one();
         mon_en = 1'b1;
         check("reset", 8'hFF, 4'hF);
      end
      rst = 1'b0;
      cyc = 0;
   endtask

   initial begin
      // Frame-load vectors with BCD_IN=1239 present from reset; first frame shows snapshot 0
      vecs[0]  = '{1,  8'hC0, 4'hE};
      vecs[1]  = '{10, 8'hC0, 4'hE};
      vecs[2]  = '{11, 8'hFF, 4'hF};
      vecs[3]  = '{12, 8'hFF, 4'hF};
      vecs[4]  = '{13, 8'hC0, 4'hD};
      vecs[5]  = '{40, 8'hC0, 4'h7};
      vecs[6]  = '{41, 8'hFF, 4'hF};
      vecs[7]  = '{43, 8'h90, 4'hE};
      vecs[8]  = '{50, 8'h90, 4'hE};
      vecs[9]  = '{51, 8'hFF, 4'hF};
      vecs[10] = '{53, 8'hB0, 4'hD};
      vecs[11] = '{63, 8'hA4, 4'hB};
      vecs[12] = '{73, 8'hF9, 4'h7};
      vecs[13] = '{80, 8'hF9, 4'h7};
      vecs[14] = '{81, 8'hFF, 4'hF};
      vecs[15] = '{83, 8'h90, 4'hE};

      bus.BCD_IN   = 16'h1239;
      bus.DP_IN    = 4'b0000;
      bus.LZ_BLANK = 1'b0;
      do_reset(3);

      for (int n = 1; n <= 90; n++) begin
         run_to(n);
         foreach (vecs[i]) begin
            if (vecs[i].n == n) check("frame", vecs[i].seg, vecs[i].sel);
         end
         if (n > 10 && ((n % 10) == 1 || (n % 10) == 2)) check("deadtime", 8'hFF, 4'hF);
      end

      // Tear-free: change mid-frame while digit1 is on
      bus.BCD_IN = 16'h0009;
      do_reset(1);
      run_to(43); check("tear_d0_old", 8'h90, 4'hE);
      run_to(53); check("tear_d1_old", 8'hC0, 4'hD);
      run_to(55);
      bus.BCD_IN = 16'h0010;
      run_to(63); check("tear_d2_old", 8'hC0, 4'hB);
      run_to(73); check("tear_d3_old", 8'hC0, 4'h7);
      run_to(83); check("tear_d0_new", 8'hC0, 4'hE);
      run_to(93); check("tear_d1_new", 8'hF9, 4'hD);

      // Leading-zero blanking, then a dp on the top digit defeats it
      bus.BCD_IN   = 16'h0070;
      bus.DP_IN    = 4'b0000;
      bus.LZ_BLANK = 1'b1;
      do_reset(1);
      run_to(13);  check("lz_boot_d1", 8'hFF, 4'hD);
      run_to(43);  check("lz_d0", 8'hC0, 4'hE);
      run_to(53);  check("lz_d1", 8'hF8, 4'hD);
      run_to(63);  check("lz_d2", 8'hFF, 4'hB);
      run_to(73);  check("lz_d3", 8'hFF, 4'h7);
      run_to(75);
      bus.DP_IN = 4'b1000;
      run_to(93);  check("lzdp_d1", 8'hF8, 4'hD);
      run_to(103); check("lzdp_d2", 8'hC0, 4'hB);
      run_to(113); check("lzdp_d3", 8'h40, 4'h7);
      bus.LZ_BLANK = 1'b0;
      bus.DP_IN    = 4'b0000;

      // Reset during the dead time of digit2
      bus.BCD_IN = 16'h1239;
      do_reset(1);
      run_to(43); check("pre_rst_d0", 8'h90, 4'hE);
      run_to(61); check("pre_rst_gap", 8'hFF, 4'hF);
      rst = 1'b1;
      tick_one();
      check("mid_reset", 8'hFF, 4'hF);
      rst = 1'b0;
      cyc = 0;
      run_to(1);  check("post_rst_d0", 8'hC0, 4'hE);
      run_to(10); check("post_rst_tick", 8'hC0, 4'hE);
      run_to(13); check("post_rst_d1", 8'hC0, 4'hD);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
